button_debounce: RTL and testbench

Front-end conditioning stage for every push-button in the design, sitting directly upstream of the button-to-address counters. Synchronises a raw, bouncing button pin into `clk`, qualifies it with a stability counter, and emits a clean level plus single-cycle press, release and optional auto-repeat strobes. Downstream stages consume `btn_level` or `btn_press` directly, so no second clock domain is needed to debounce.

---
 rtl/button_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/button_debounce.sv | 124 ++++++++++++
 tb/tb_button_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and constants for push-button conditioning.
// Holds the debounce FSM states, counter sizing helpers and 100 MHz board defaults.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    // 10 ms debounce, 500 ms hold before first repeat, 200 ms repeat period
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned HOLD_CYCLES_DEF     = 50_000_000;
    localparam int unsigned REPEAT_CYCLES_DEF   = 20_000_000;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Counter only ever holds values up to max_val-1, so clog2(max_val) bits suffice.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val <= 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs.
// Two-cycle latency, no backpressure.
module sync_2ff #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_debounce.sv
// Debounces a raw button into a clean level plus press/release/auto-repeat strobes.
// Press/release accepted DEBOUNCE_CYCLES+3 edges after the pin settles; no backpressure.
module button_debounce
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit          REPEAT_EN       = 1'b0,
    parameter int unsigned HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int unsigned REPEAT_CYCLES   = REPEAT_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int unsigned CW = cnt_width(max3(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES));

    localparam logic [CW-1:0] DEB_LIM  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] REP_LIM  = CW'(REPEAT_CYCLES - 1);

    logic          s2;
    state_t        state_q, state_n;
    logic [CW-1:0] cnt_q, cnt_n;
    logic          first_done_q, first_done_n;
    logic          level_n, press_n, release_n, repeat_n;
    logic [CW-1:0] rep_lim;

    sync_2ff #(.WIDTH(1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (s2)
    );

    assign rep_lim = first_done_q ? REP_LIM : HOLD_LIM;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            first_done_q <= 1'b0;
            btn_level    <= 1'b0;
            btn_press    <= 1'b0;
            btn_release  <= 1'b0;
            btn_repeat   <= 1'b0;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            first_done_q <= first_done_n;
            btn_level    <= level_n;
            btn_press    <= press_n;
            btn_release  <= release_n;
            btn_repeat   <= repeat_n;
        end
    end

    always_comb begin
        state_n      = state_q;
        cnt_n        = cnt_q;
        first_done_n = first_done_q;
        level_n      = btn_level;
        press_n      = 1'b0;
        release_n    = 1'b0;
        repeat_n     = 1'b0;

        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_n = IDLE;
                end else if (cnt_q == DEB_LIM) begin
                    state_n      = PRESSED;
                    cnt_n        = '0;
                    first_done_n = 1'b0;
                    level_n      = 1'b1;
                    press_n      = 1'b1;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = '0;
                end else if (REPEAT_EN) begin
                    if (cnt_q == rep_lim) begin
                        repeat_n     = 1'b1;
                        cnt_n        = '0;
                        first_done_n = 1'b1;
                    end else begin
                        cnt_n = cnt_q + CW'(1);
                    end
                end
                // With repeat disabled the counter idles at 0 so it can never wrap.
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt_q == DEB_LIM) begin
                    state_n   = IDLE;
                    level_n   = 1'b0;
                    release_n = 1'b1;
                end else begin
                    cnt_n = cnt_q + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_button_debounce.sv
// Scoreboard bench: two instances (repeat on/off) share one stimulus stream;
// expected strobes are queued with their cycle and popped as the DUTs emit them.
module tb_button_debounce;

    localparam int EV_PRESS = 1;
    localparam int EV_REL   = 2;
    localparam int EV_REP   = 4;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    logic btn_in;
    logic a_level, a_press, a_release, a_repeat;
    logic b_level, b_press, b_release, b_repeat;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b1),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5)
    ) dut_a (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (a_level),
        .btn_press   (a_press),
        .btn_release (a_release),
        .btn_repeat  (a_repeat)
    );

    button_debounce #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1'b0),
        .HOLD_CYCLES     (10),
        .REPEAT_CYCLES   (5)
    ) dut_b (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_in      (btn_in),
        .btn_level   (b_level),
        .btn_press   (b_press),
        .btn_release (b_release),
        .btn_repeat  (b_repeat)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    task automatic push_a(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        qa.push_back(e);
    endtask

    task automatic push_b(input int kind, input int c);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        qb.push_back(e);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Strobe kinds are one-hot, so a merged pair of strobes shows up as a kind mismatch.
    always @(negedge clk) begin
        ev_t e;
        int  k;
        k = {29'd0, a_repeat, a_release, a_press};
        if (k != 0) begin
            if (qa.size() == 0) chk("a_unexpected", k, 0);
            else begin
                e = qa.pop_front();
                chk("a_kind", k, e.kind);
                chk("a_cycle", cyc, e.cyc);
            end
        end
        k = {29'd0, b_repeat, b_release, b_press};
        if (k != 0) begin
            if (qb.size() == 0) chk("b_unexpected", k, 0);
            else begin
                e = qb.pop_front();
                chk("b_kind", k, e.kind);
                chk("b_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int t, u, v, w, tr;
        rst_n  = 1'b0;
        btn_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_a_level", a_level, 0);
        chk("rst_a_press", a_press, 0);
        chk("rst_a_release", a_release, 0);
        chk("rst_a_repeat", a_repeat, 0);
        chk("rst_b_level", b_level, 0);
        chk("rst_b_press", b_press, 0);
        chk("rst_b_release", b_release, 0);
        chk("rst_b_repeat", b_repeat, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Clean press, then hold for the auto-repeat train
        t = cyc;
        btn_in = 1'b1;
        push_a(EV_PRESS, t + 7);
        push_b(EV_PRESS, t + 7);
        for (int k = 0; k < 6; k++) push_a(EV_REP, t + 17 + 5 * k);
        wait_until(t + 6);
        chk("clean_a_level_pre", a_level, 0);
        chk("clean_b_level_pre", b_level, 0);
        wait_until(t + 7);
        chk("clean_a_level", a_level, 1);
        chk("clean_b_level", b_level, 1);

        // Release with a one-cycle glitch back high
        wait_until(t + 43);
        tr = cyc;
        btn_in = 1'b0;
        wait_until(tr + 2);
        btn_in = 1'b1;
        wait_until(tr + 3);
        btn_in = 1'b0;
        push_a(EV_REL, tr + 10);
        push_b(EV_REL, tr + 10);
        wait_until(tr + 5);
        chk("glitch_a_level", a_level, 1);
        wait_until(tr + 9);
        chk("glitch_a_level_late", a_level, 1);
        chk("glitch_b_level_late", b_level, 1);
        wait_until(tr + 10);
        chk("rel_a_level", a_level, 0);
        chk("rel_b_level", b_level, 0);

        // Bouncy press 1,1,0,1,1,0 then steady 1
        wait_until(tr + 20);
        u = cyc;
        btn_in = 1'b1;
        wait_until(u + 2);
        btn_in = 1'b0;
        wait_until(u + 3);
        btn_in = 1'b1;
        wait_until(u + 5);
        btn_in = 1'b0;
        wait_until(u + 6);
        btn_in = 1'b1;
        push_a(EV_PRESS, u + 13);
        push_b(EV_PRESS, u + 13);
        wait_until(u + 12);
        chk("bounce_a_level_pre", a_level, 0);
        wait_until(u + 13);
        chk("bounce_a_level", a_level, 1);

        // Reset three cycles into the hold
        wait_until(u + 16);
        chk("pre_rst_a_pending", qa.size(), 0);
        chk("pre_rst_b_level", b_level, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_a_level", a_level, 0);
        chk("arst_b_level", b_level, 0);
        chk("arst_a_strobes", {a_press, a_release, a_repeat}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        v = cyc;
        push_a(EV_PRESS, v + 7);
        push_b(EV_PRESS, v + 7);
        for (int k = 0; k < 6; k++) push_a(EV_REP, v + 17 + 5 * k);
        wait_until(v + 7);
        chk("post_rst_a_level", a_level, 1);

        // Long hold and clean release; instance b must never repeat
        wait_until(v + 43);
        w = cyc;
        btn_in = 1'b0;
        push_a(EV_REL, w + 7);
        push_b(EV_REL, w + 7);
        wait_until(w + 7);
        chk("final_b_level", b_level, 0);
        chk("final_b_repeat", b_repeat, 0);
        wait_until(w + 30);
        chk("end_a_pending", qa.size(), 0);
        chk("end_b_pending", qb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
